// File: rtl/vga_pkg.sv
// vga_pkg: constants and types shared by the VGA record display blocks.
//   hbp/hfp/vbp/vfp : visible-area bounds of the VGA timing counters
//   DIGITS/DIGIT_W  : record layout, seven 4-bit BCD digits
//   record_t        : one 28-bit record, [3:0] = led1 ... [27:24] = led7
package vga_pkg;

  localparam int unsigned hbp = 144;
  localparam int unsigned hfp = 784;
  localparam int unsigned vbp = 35;
  localparam int unsigned vfp = 515;

  localparam int unsigned DIGITS  = 7;
  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGITS*DIGIT_W-1:0] record_t;

endpackage

// File: rtl/record_ram.sv
// record_ram: DEPTH x 28-bit record storage.
//   clk   : write clock
//   we    : write enable, stores wdata at waddr on the rising edge
//   waddr : write address
//   wdata : record to store
//   raddr : combinational read address
//   rdata : record at raddr
// Contents are not reset; the controller never displays a slot before it is written.
module record_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [DIGITS*DIGIT_W-1:0] wdata,
  input  logic [AW-1:0]             raddr,
  output logic [DIGITS*DIGIT_W-1:0] rdata
);

  record_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vga_record_ctrl.sv
// vga_record_ctrl: circular buffer of BCD records with a tear-free display
// selector. Display outputs only change on the edge ending a frame_tick cycle
// (hc == 0 && vc == 0).
//   clk, rst               : clock, asynchronous active-high reset
//   rec_valid, rec_data    : store a new record (pulse)
//   next                   : select the next-older record (pulse)
//   clear                  : erase all records (pulse)
//   hc, vc                 : VGA horizontal/vertical counters
//   has_record, led1..led7 : displayed record, to the digit renderer
//   rec_count, full        : number of stored records, buffer full
//   rec_sel                : age of the displayed record (0 = newest)
// Optional macro VGA_RECORD_AUTOSCROLL_EN adds a frame counter that issues an
// implicit next every AUTO_FRAMES frames while showing more than one record.
module vga_record_ctrl
  import vga_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int AUTO_FRAMES = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_valid,
  input  logic [27:0] rec_data,
  input  logic        next,
  input  logic        clear,
  input  logic [9:0]  hc,
  input  logic [9:0]  vc,
  output logic        has_record,
  output logic [3:0]  led1,
  output logic [3:0]  led2,
  output logic [3:0]  led3,
  output logic [3:0]  led4,
  output logic [3:0]  led5,
  output logic [3:0]  led6,
  output logic [3:0]  led7,
  output logic [3:0]  rec_count,
  output logic [2:0]  rec_sel,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vga_record_ctrl: DEPTH must be a power of 2 in 2..8");
  end
  if (AUTO_FRAMES < 1) begin : g_bad_auto
    $error("vga_record_ctrl: AUTO_FRAMES must be at least 1");
  end

  typedef enum logic [1:0] {ST_EMPTY, ST_SHOW, ST_PEND} state_t;

  state_t        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [3:0]    count_q;
  logic [2:0]    sel_pend_q;
  logic [2:0]    sel_q;
  logic          has_q;
  logic          full_q;
  record_t       led_q;

  logic          frame_tick;
  logic          do_write;
  logic          do_next;
  logic          auto_next;
  logic [2:0]    sel_adv;
  logic [2:0]    rd_sel;
  logic [AW-1:0] rd_addr;
  logic [3:0]    count_inc;
  record_t       rd_data;

  assign frame_tick = (hc == '0) && (vc == '0);

  // clear beats rec_valid, rec_valid beats next
  assign do_write = rec_valid && !clear;
  assign do_next  = next && !rec_valid && !clear &&
                    (state_q != ST_EMPTY) && (count_q > 4'd1);

  assign sel_adv   = ((4'(sel_pend_q) + 4'd1) >= count_q) ? '0 : sel_pend_q + 3'd1;
  assign count_inc = (count_q == 4'(DEPTH)) ? count_q : count_q + 4'd1;

  // Age 0 is the slot just behind wr_ptr; DEPTH is a power of 2 so
  // truncation gives the modulo.
  assign rd_sel  = auto_next ? sel_adv : sel_pend_q;
  assign rd_addr = AW'(3'(wr_ptr_q) - 3'd1 - rd_sel);

`ifdef VGA_RECORD_AUTOSCROLL_EN
  localparam int FW = $clog2(AUTO_FRAMES + 1);
  logic [FW-1:0] frame_cnt_q;

  // Fires on the tick itself and updates the display on that same edge,
  // so each record stays up for exactly AUTO_FRAMES frames.
  assign auto_next = (state_q == ST_SHOW) && frame_tick && (count_q > 4'd1) &&
                     !clear && !rec_valid && !next &&
                     (frame_cnt_q == FW'(AUTO_FRAMES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (clear || rec_valid || next || auto_next) begin
      frame_cnt_q <= '0;
    end else if ((state_q == ST_SHOW) && frame_tick && (count_q > 4'd1)) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end
`else
  assign auto_next = 1'b0;
`endif

  record_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_ptr_q),
    .wdata (rec_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      sel_pend_q <= '0;
      sel_q      <= '0;
      has_q      <= 1'b0;
      full_q     <= 1'b0;
      led_q      <= '0;
    end else if (clear) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      full_q     <= 1'b0;
      sel_pend_q <= '0;
      if (state_q != ST_EMPTY) state_q <= ST_PEND;
    end else if (do_write) begin
      count_q    <= count_inc;
      full_q     <= (count_inc == 4'(DEPTH));
      wr_ptr_q   <= wr_ptr_q + 1'b1;
      sel_pend_q <= '0;
      state_q    <= ST_PEND;
    end else if (do_next) begin
      sel_pend_q <= sel_adv;
      state_q    <= ST_PEND;
    end else if (frame_tick) begin
      case (state_q)
        ST_PEND: begin
          if (count_q == '0) begin
            state_q <= ST_EMPTY;
            has_q   <= 1'b0;
            led_q   <= '0;
            sel_q   <= '0;
          end else begin
            state_q <= ST_SHOW;
            has_q   <= 1'b1;
            led_q   <= rd_data;
            sel_q   <= sel_pend_q;
          end
        end
        ST_SHOW: begin
          if (auto_next) begin
            sel_pend_q <= sel_adv;
            sel_q      <= sel_adv;
            led_q      <= rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign has_record = has_q;
  assign led1       = led_q[3:0];
  assign led2       = led_q[7:4];
  assign led3       = led_q[11:8];
  assign led4       = led_q[15:12];
  assign led5       = led_q[19:16];
  assign led6       = led_q[23:20];
  assign led7       = led_q[27:24];
  assign rec_count  = count_q;
  assign rec_sel    = sel_q;
  assign full       = full_q;

endmodule

// File: tb/tb_vga_record_ctrl.sv
// Directed bench for vga_record_ctrl (DEPTH=4, AUTO_FRAMES=2). Counters are
// driven directly: idle at hc=5/vc=200, one cycle at 0/0 forms a frame_tick.
module tb_vga_record_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rec_valid;
  logic [27:0] rec_data;
  logic        next;
  logic        clear;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        has_record;
  logic [3:0]  led1, led2, led3, led4, led5, led6, led7;
  logic [3:0]  rec_count;
  logic [2:0]  rec_sel;
  logic        full;
  logic [27:0] leds;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  assign leds = {led7, led6, led5, led4, led3, led2, led1};

  always #5 clk = ~clk;

  vga_record_ctrl #(
    .DEPTH       (4),
    .AUTO_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rec_valid  (rec_valid),
    .rec_data   (rec_data),
    .next       (next),
    .clear      (clear),
    .hc         (hc),
    .vc         (vc),
    .has_record (has_record),
    .led1       (led1),
    .led2       (led2),
    .led3       (led3),
    .led4       (led4),
    .led5       (led5),
    .led6       (led6),
    .led7       (led7),
    .rec_count  (rec_count),
    .rec_sel    (rec_sel),
    .full       (full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic h, input logic [27:0] l,
                            input logic [2:0] s);
    check({tag, "/has"}, 32'(has_record), 32'(h));
    check({tag, "/leds"}, 32'(leds), 32'(l));
    check({tag, "/sel"}, 32'(rec_sel), 32'(s));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    hc = '0; vc = '0;
    step();
    hc = 10'd5; vc = 10'd200;
  endtask

  task automatic put(input logic [27:0] d);
    rec_valid = 1'b1; rec_data = d;
    step();
    rec_valid = 1'b0;
  endtask

  task automatic do_next();
    next = 1'b1;
    step();
    next = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rec_valid = 1'b0; rec_data = '0; next = 1'b0; clear = 1'b0;
    hc = 10'd5; vc = 10'd200;
    step();
    step();
    check_disp("reset", 1'b0, 28'h0, 3'd0);
    check("reset/count", 32'(rec_count), 32'd0);
    check("reset/full", 32'(full), 32'd0);
    rst = 1'b0;

    // store then display
    put(28'h7654321);
    check("store/count", 32'(rec_count), 32'd1);
    check("store/has_before_tick", 32'(has_record), 32'd0);
    tick();
    check_disp("store", 1'b1, 28'h7654321, 3'd0);

    // mid-frame write is held until the next frame_tick
    put(28'h1111111);
    check("tear/leds_held", 32'(leds), 32'h7654321);
    step(); step();
    check("tear/leds_still_held", 32'(leds), 32'h7654321);
    check("tear/count", 32'(rec_count), 32'd2);
    tick();
    check_disp("tear", 1'b1, 28'h1111111, 3'd0);

    // write in the frame_tick cycle shows only at the following tick
    hc = '0; vc = '0;
    put(28'h2222222);
    hc = 10'd5; vc = 10'd200;
    check("tickwr/leds_held", 32'(leds), 32'h1111111);
    tick();
    check_disp("tickwr", 1'b1, 28'h2222222, 3'd0);

    // clear + rec_valid together: clear wins
    clear = 1'b1;
    put(28'h3333333);
    clear = 1'b0;
    check("clrval/count", 32'(rec_count), 32'd0);
    check("clrval/has_before_tick", 32'(has_record), 32'd1);
    tick();
    check_disp("clrval", 1'b0, 28'h0, 3'd0);

    // wrap and overwrite: A..E into four slots, E overwrites A
    put(28'h1000001);
    put(28'h2000002);
    put(28'h3000003);
    check("wrap/full_at_3", 32'(full), 32'd0);
    put(28'h4000004);
    check("wrap/full_at_4", 32'(full), 32'd1);
    put(28'h5000005);
    check("wrap/count", 32'(rec_count), 32'd4);
    check("wrap/full", 32'(full), 32'd1);
    tick();
    check_disp("wrap0", 1'b1, 28'h5000005, 3'd0);
    do_next(); tick();
    check_disp("wrap1", 1'b1, 28'h4000004, 3'd1);
    do_next(); tick();
    check_disp("wrap2", 1'b1, 28'h3000003, 3'd2);
    do_next(); tick();
    check_disp("wrap3", 1'b1, 28'h2000002, 3'd3);
    do_next(); tick();
    check_disp("wrap4", 1'b1, 28'h5000005, 3'd0);

    // rec_valid + next together: rec_valid wins, selection back to newest
    do_next(); tick();
    check("valnext/sel_before", 32'(rec_sel), 32'd1);
    next = 1'b1;
    put(28'h6000006);
    next = 1'b0;
    tick();
    check_disp("valnext", 1'b1, 28'h6000006, 3'd0);
    check("valnext/count", 32'(rec_count), 32'd4);

    // next ignored while empty and with a single record
    do_clear(); tick();
    do_next(); tick();
    check_disp("next_empty", 1'b0, 28'h0, 3'd0);
    put(28'h9876543); tick();
    do_next(); tick();
    check_disp("next_single", 1'b1, 28'h9876543, 3'd0);

    // reset during PEND clears outputs at once and aborts the update
    put(28'h1234567);
    rst = 1'b1;
    #1;
    check_disp("rstpend", 1'b0, 28'h0, 3'd0);
    check("rstpend/count", 32'(rec_count), 32'd0);
    #2;
    rst = 1'b0;
    tick();
    check_disp("rstpend_tick", 1'b0, 28'h0, 3'd0);

`ifdef VGA_RECORD_AUTOSCROLL_EN
    put(28'h0000001);
    put(28'h0000002);
    put(28'h0000003);
    tick();
    check("auto/sel0", 32'(rec_sel), 32'd0);
    tick(); check("auto/sel1", 32'(rec_sel), 32'd0);
    tick(); check("auto/sel2", 32'(rec_sel), 32'd1);
    check("auto/leds2", 32'(leds), 32'h0000002);
    tick(); check("auto/sel3", 32'(rec_sel), 32'd1);
    tick(); check("auto/sel4", 32'(rec_sel), 32'd2);
    tick(); check("auto/sel5", 32'(rec_sel), 32'd2);
    tick(); check("auto/sel6", 32'(rec_sel), 32'd0);
    check("auto/leds6", 32'(leds), 32'h0000003);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_record_ctrl.md
VGA_RECORD_CTRL -- requirements
Module: vga_record_ctrl

Interface
REQ-001 Parameter DEPTH, default 4: number of record slots in the circular buffer (power of 2, 2..8).
REQ-002 Parameter AUTO_FRAMES, default 120: frames between auto-scroll steps, used only when the auto-scroll macro is defined.
REQ-003 clk  in  1  system clock (pixel-clock domain, same clock as hc/vc counters).
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 rec_valid  in  1  single-cycle pulse: store rec_data as a new record.
REQ-006 rec_data  in  28  seven BCD digits; [3:0]=led1 … [27:24]=led7.
REQ-007 next  in  1  single-cycle pulse: select the next-older record.
REQ-008 clear  in  1  single-cycle pulse: erase all records.
REQ-009 hc, vc  in  10 each  current VGA horizontal/vertical counters.
REQ-010 has_record  out  1  high while a valid record is displayed.
REQ-011 led1..led7  out  4 each  digits of the displayed record.
REQ-012 rec_count  out  4  number of stored records (0..DEPTH).
REQ-013 rec_sel  out  3  displayed record age (0 = newest).
REQ-014 full  out  1  rec_count == DEPTH.

Function
REQ-015 frame_tick is the cycle where hc==0 and vc==0; display outputs (has_record, led1..led7, rec_sel) change only on the clk edge ending a frame_tick cycle, so they become visible one cycle after it.
REQ-016 Store path: rec_valid writes rec_data at wr_ptr and increments wr_ptr modulo DEPTH in the same cycle; rec_count increments and saturates at DEPTH.
REQ-017 When full, a write overwrites the oldest record; rec_count stays DEPTH.
REQ-018 State machine: EMPTY (rec_count==0), SHOW (outputs match the selection), PEND (selection or contents changed, waiting for frame_tick).
REQ-019 EMPTY->PEND on rec_valid; SHOW->PEND on rec_valid, next or clear; PEND->SHOW on frame_tick, or ->EMPTY on frame_tick if rec_count==0.
REQ-020 rec_valid resets the pending selection to age 0 (newest).
REQ-021 next advances the pending selection by one age, wrapping from rec_count-1 to 0; next is ignored in EMPTY or when rec_count==1.
REQ-022 clear zeroes rec_count and wr_ptr; has_record and led1..led7 become 0 at the next frame_tick.
REQ-023 Simultaneous pulses: clear wins over rec_valid, and rec_valid wins over next; the losing pulses are dropped.
REQ-024 rec_valid in a frame_tick cycle: the record is stored, and the display shows it at the following frame_tick (not the current one).
REQ-025 rec_count, full and rec_sel are registered; rec_count and full update one cycle after the triggering pulse.

Reset
REQ-026 On rst, the block enters EMPTY and every output reads 0, including has_record, led1..led7, rec_count, rec_sel and full.
REQ-027 On rst, wr_ptr and the pending selection read 0; record storage contents need not be cleared but are never displayed until rewritten.
REQ-028 rst asserted mid-frame or during PEND aborts the pending update.

Configuration
REQ-029 Macro VGA_RECORD_AUTOSCROLL_EN.
REQ-030 With VGA_RECORD_AUTOSCROLL_EN defined: in SHOW with rec_count>1, a frame counter acts as an implicit next every AUTO_FRAMES frame_ticks.
REQ-031 With VGA_RECORD_AUTOSCROLL_EN defined: the frame counter restarts on next, rec_valid, clear and rst.
REQ-032 Without VGA_RECORD_AUTOSCROLL_EN: no frame counter is built, and selection changes only via next and rec_valid.

Structure
REQ-033 Shared package vga_pkg holds the timing constants hbp=144, hfp=784, vbp=35, vfp=515, plus DIGITS=7, DIGIT_W=4 and the 28-bit record typedef.
REQ-034 Sub-module record_ram holds the DEPTH x 28 storage, with one synchronous write port and one combinational read port addressed by (wr_ptr-1-sel) mod DEPTH.
REQ-035 The block drives the existing VGA digit renderer directly through has_record and led1..led7.

Verification
REQ-036 Store then display: rst, rec_valid with data 0x7654321, wait for frame_tick -> has_record=1, led7..led1=7,6,5,4,3,2,1 one cycle after the tick, rec_count=1.
REQ-037 Tear-free: write 0x1111111 while in SHOW mid-frame (vc=200) -> led outputs unchanged until the next hc=0,vc=0, then read 1.
REQ-038 Wrap and overwrite: DEPTH=4, write records A..E, then next x4 across frames -> displays E,D,C,B,E; full=1; rec_count=4.
REQ-039 Simultaneous pulses: clear+rec_valid in the same cycle -> rec_count=0 and has_record=0 after the next frame_tick; rec_valid+next together -> rec_sel=0.
REQ-040 Reset mid-operation: assert rst during PEND -> all outputs read 0 immediately, with no update at the next frame_tick.
REQ-041 Auto-scroll (macro defined, AUTO_FRAMES=2): 3 records, no input -> rec_sel sequence 0,0,1,1,2,2,0 over frames.
